// File: rtl/min_val_less_8x_with_index.sv
`default_nettype none
// ============================================================================
// Module      : min_val_less_8x_with_index
// Description : Selects the minimum unsigned value among up to 8 tagged
//               channels. Invalid channels are ignored. The block reports the
//               minimum and a one-hot mask of the winning channel. A one-cycle
//               registered copy of both outputs is also provided.
//
//               The reduction is a balanced pairwise tree. Each node carries
//               (value, valid, one-hot). Ties resolve to the lower channel.
//
// Parameters  : DATA_WIDTH    - width of each channel value (unsigned)
//               CHANNEL_COUNT - number of channels, 1..8
//
// Ports       : clk               - clock for the registered copy
//               reset_n           - asynchronous active-low reset
//               values            - packed channel values, channel 0 at LSBs
//               valids            - per-channel participation flags
//               result            - combinational minimum (all ones if none)
//               output_valids     - combinational one-hot winner mask
//               result_reg        - result, registered
//               output_valids_reg - output_valids, registered
//               min_index         - binary winner index  (MIN_VAL_INDEX_OUT_EN)
//               min_index_reg     - min_index, registered (MIN_VAL_INDEX_OUT_EN)
//
// Options     : MIN_VAL_INDEX_OUT_EN - adds the binary index outputs
//
// Revision    : 1.0 - initial release
// ============================================================================
module min_val_less_8x_with_index #(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_COUNT = 6
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] values,
    input  logic [CHANNEL_COUNT-1:0]            valids,
    output logic [DATA_WIDTH-1:0]               result,
    output logic [CHANNEL_COUNT-1:0]            output_valids,
    output logic [DATA_WIDTH-1:0]               result_reg,
    output logic [CHANNEL_COUNT-1:0]            output_valids_reg
`ifdef MIN_VAL_INDEX_OUT_EN
    ,
    output logic [((CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1)-1:0] min_index,
    output logic [((CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1)-1:0] min_index_reg
`endif
);

    localparam int c_LEVELS = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 0;
    localparam int c_IDX_W  = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;

    // ------------------------------------------------------------------------
    // Reduction tree, evaluated in place. On level L, node j merges nodes 2j
    // (A, lower channels) and 2j+1 (B, higher channels). Writing slot j only
    // after reading 2j and 2j+1 is safe because j <= 2j. An odd leftover
    // node passes through unchanged.
    // ------------------------------------------------------------------------
    always_comb begin : p_tree
        logic [DATA_WIDTH-1:0]    w_val [CHANNEL_COUNT];
        logic                     w_vld [CHANNEL_COUNT];
        logic [CHANNEL_COUNT-1:0] w_oh  [CHANNEL_COUNT];
        int                       w_n;
        int                       w_a;
        int                       w_b;

        // Invalid leaves are normalised to the "empty node" form. The root
        // then needs no final masking.
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            w_oh[i]  = '0;
            w_vld[i] = valids[i];
            if (valids[i]) begin
                w_val[i]    = values[i*DATA_WIDTH +: DATA_WIDTH];
                w_oh[i][i]  = 1'b1;
            end else begin
                w_val[i]    = '1;
            end
        end

        w_n = CHANNEL_COUNT;
        w_a = 0;
        w_b = 0;
        for (int lvl = 0; lvl < c_LEVELS; lvl++) begin
            for (int j = 0; j < CHANNEL_COUNT; j++) begin
                if (2*j < w_n) begin
                    w_a = 2*j;
                    // Clamp B to a legal slot. It is used only when it exists.
                    w_b = (2*j+1 < CHANNEL_COUNT) ? 2*j+1 : 2*j;
                    if (2*j+1 < w_n) begin
                        if (w_vld[w_b] && (!w_vld[w_a] || (w_val[w_b] < w_val[w_a]))) begin
                            w_val[j] = w_val[w_b];
                            w_vld[j] = 1'b1;
                            w_oh[j]  = w_oh[w_b];
                        end else if (w_vld[w_a]) begin
                            w_val[j] = w_val[w_a];
                            w_vld[j] = 1'b1;
                            w_oh[j]  = w_oh[w_a];
                        end else begin
                            w_val[j] = '1;
                            w_vld[j] = 1'b0;
                            w_oh[j]  = '0;
                        end
                    end else begin
                        w_val[j] = w_val[w_a];
                        w_vld[j] = w_vld[w_a];
                        w_oh[j]  = w_oh[w_a];
                    end
                end
            end
            w_n = (w_n + 1) / 2;
        end

        result        = w_val[0];
        output_valids = w_oh[0];
    end

`ifdef MIN_VAL_INDEX_OUT_EN
    // The binary index is encoded from the one-hot winner mask. At most one
    // bit is set, so OR-ing the positions gives the index. The index is 0
    // when the mask is empty.
    always_comb begin : p_index_enc
        min_index = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (output_valids[i]) begin
                min_index = min_index | c_IDX_W'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Registered copy: updates every edge, no enable.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin : p_regs
        if (!reset_n) begin
            result_reg        <= '1;
            output_valids_reg <= '0;
`ifdef MIN_VAL_INDEX_OUT_EN
            min_index_reg     <= '0;
`endif
        end else begin
            result_reg        <= result;
            output_valids_reg <= output_valids;
`ifdef MIN_VAL_INDEX_OUT_EN
            min_index_reg     <= min_index;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_min_val_less_8x_with_index.sv
`default_nettype none
// ============================================================================
// Module      : tb_min_val_less_8x_with_index
// Description : Self-checking bench for min_val_less_8x_with_index. The bench
//               applies directed cases and randomized stimulus. It compares
//               both output paths against a linear-scan reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_min_val_less_8x_with_index;

    localparam int c_DW  = 8;
    localparam int c_CH  = 6;
    localparam int c_IW  = 3;

    logic                   clk;
    logic                   reset_n;
    logic [c_DW*c_CH-1:0]   values;
    logic [c_CH-1:0]        valids;
    logic [c_DW-1:0]        result;
    logic [c_CH-1:0]        output_valids;
    logic [c_DW-1:0]        result_reg;
    logic [c_CH-1:0]        output_valids_reg;
`ifdef MIN_VAL_INDEX_OUT_EN
    logic [c_IW-1:0]        min_index;
    logic [c_IW-1:0]        min_index_reg;
`endif

    int errors = 0;
    int checks = 0;

    min_val_less_8x_with_index #(
        .DATA_WIDTH    (c_DW),
        .CHANNEL_COUNT (c_CH)
    ) u_dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .values            (values),
        .valids            (valids),
        .result            (result),
        .output_valids     (output_valids),
        .result_reg        (result_reg),
        .output_valids_reg (output_valids_reg)
`ifdef MIN_VAL_INDEX_OUT_EN
        ,
        .min_index         (min_index),
        .min_index_reg     (min_index_reg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: linear scan with strict less-than. A later channel replaces
    // the current best only when it is smaller, so ties keep the lowest index.
    task automatic model(input logic [c_DW*c_CH-1:0] v, input logic [c_CH-1:0] vl,
                         output logic [c_DW-1:0] r, output logic [c_CH-1:0] m,
                         output int idx);
        int best;
        best = -1;
        for (int i = 0; i < c_CH; i++) begin
            if (vl[i]) begin
                if (best < 0 || v[i*c_DW +: c_DW] < v[best*c_DW +: c_DW]) best = i;
            end
        end
        if (best < 0) begin
            r   = '1;
            m   = '0;
            idx = 0;
        end else begin
            r   = v[best*c_DW +: c_DW];
            m   = '0;
            m[best] = 1'b1;
            idx = best;
        end
    endtask

    logic [c_DW-1:0] exp_r;
    logic [c_CH-1:0] exp_m;
    int              exp_i;

    task automatic check_comb(input string tag);
        model(values, valids, exp_r, exp_m, exp_i);
        check({tag, ".result"}, 32'(result), 32'(exp_r));
        check({tag, ".ovalids"}, 32'(output_valids), 32'(exp_m));
`ifdef MIN_VAL_INDEX_OUT_EN
        check({tag, ".min_index"}, 32'(min_index), 32'(exp_i));
`endif
    endtask

    task automatic check_reg(input string tag, input logic [c_DW-1:0] r,
                             input logic [c_CH-1:0] m, input int idx);
        check({tag, ".result_reg"}, 32'(result_reg), 32'(r));
        check({tag, ".ovalids_reg"}, 32'(output_valids_reg), 32'(m));
`ifdef MIN_VAL_INDEX_OUT_EN
        check({tag, ".min_index_reg"}, 32'(min_index_reg), 32'(idx));
`endif
    endtask

    task automatic apply(input logic [c_DW*c_CH-1:0] v, input logic [c_CH-1:0] vl);
        values = v;
        valids = vl;
    endtask

    logic [c_DW*c_CH-1:0] rv;
    logic [c_DW-1:0]      pr;
    logic [c_CH-1:0]      pm;
    int                   pi;

    initial begin
        reset_n = 1'b1;
        values  = '0;
        valids  = '0;
        #1 reset_n = 1'b0;
        #2;
        check_reg("reset", 8'hFF, 6'b0, 0);

        // Directed combinational cases. Reset is still active; the
        // combinational outputs must not depend on it.
        apply({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 6'b111111);
        #1;
        check("case1.result", 32'(result), 32'h01);
        check("case1.ovalids", 32'(output_valids), 32'b100000);
`ifdef MIN_VAL_INDEX_OUT_EN
        check("case1.min_index", 32'(min_index), 32'd5);
`endif
        check_reg("reset_hold", 8'hFF, 6'b0, 0);

        apply({8'h05, 8'h00, 8'hFF, 8'h04, 8'h03, 8'h02}, 6'b100111);
        #1;
        check("case2.result", 32'(result), 32'h02);
        check("case2.ovalids", 32'(output_valids), 32'b000001);

        apply({8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 6'b000000);
        #1;
        check("none.result", 32'(result), 32'hFF);
        check("none.ovalids", 32'(output_valids), 32'b0);

        apply({8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00}, 6'b010100);
        #1;
        check("tie.result", 32'(result), 32'h10);
        check("tie.ovalids", 32'(output_valids), 32'b000100);

        apply({8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00}, 6'b001000);
        #1;
        check("ones.result", 32'(result), 32'hFF);
        check("ones.ovalids", 32'(output_valids), 32'b001000);

        // Release reset, then check that the first edge captures case 1.
        @(negedge clk);
        reset_n = 1'b1;
        apply({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 6'b111111);
        @(posedge clk);
        #1;
        check_reg("first_edge", 8'h01, 6'b100000, 5);

        // Randomized stimulus. Narrow value ranges force frequent ties.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            for (int c = 0; c < c_CH; c++) begin
                case ($urandom_range(0, 3))
                    0:       rv[c*c_DW +: c_DW] = 8'($urandom_range(0, 3));
                    1:       rv[c*c_DW +: c_DW] = 8'hFF;
                    default: rv[c*c_DW +: c_DW] = 8'($urandom);
                endcase
            end
            apply(rv, ($urandom_range(0, 7) == 0) ? 6'b0 : 6'($urandom));
            #1;
            check_comb("rand");
            pr = exp_r;
            pm = exp_m;
            pi = exp_i;
            @(posedge clk);
            #1;
            check_reg("rand", pr, pm, pi);
        end

        // Mid-stream reset clears the registers without a clock edge.
        @(negedge clk);
        apply({8'h07, 8'h03, 8'h09, 8'h03, 8'h08, 8'h0A}, 6'b111111);
        @(posedge clk);
        #1;
        check_reg("pre_midreset", 8'h03, 6'b000100, 2);
        #2 reset_n = 1'b0;
        #1;
        check_reg("midreset", 8'hFF, 6'b0, 0);
        check_comb("midreset_comb");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reg("post_midreset", 8'h03, 6'b000100, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
